beat_sequencer: RTL

BEAT_SEQUENCER -- requirements
Module: beat_sequencer

---
 rtl/baby_pkg.sv | 16 +
 rtl/beat_sequencer_digit_counter.sv | 44 ++++
 rtl/beat_sequencer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/baby_pkg.sv
// Shared types and default timing constants for the beat sequencer.
// Provides the beat-state enum and the default digit counts per beat.
package baby_pkg;

    // One beat = WORD_DIGITS data digits followed by BLACKOUT_DIGITS blanking.
    localparam int DEF_WORD_DIGITS     = 32;
    localparam int DEF_BLACKOUT_DIGITS = 4;

    typedef enum logic [1:0] {
        ST_HALT   = 2'd0,
        ST_SCAN1  = 2'd1,
        ST_SCAN2  = 2'd2,
        ST_ACTION = 2'd3
    } beat_state_e;

endpackage

// File: rtl/beat_sequencer_digit_counter.sv
// Digit-period counter: counts 0..LEN-1 while enabled and wraps to 0.
// Ports: clk, rst (async high), clr_i (force 0), en_i (advance),
//        count_o (current), count_nxt_o (value after this clock),
//        tc_o (terminal count, count_o == LEN-1).
module digit_counter #(
    parameter int LEN = 36,
    parameter int W   = $clog2(LEN)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] count_o,
    output logic [W-1:0] count_nxt_o,
    output logic         tc_o
);

    localparam logic [W-1:0] LAST = W'(LEN - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o     = count_q;
    assign count_nxt_o = count_d;
    assign tc_o        = (count_q == LAST);

endmodule

// File: rtl/beat_sequencer.sv
// Beat sequencer: steps HALT -> SCAN1 -> SCAN2 -> ACTION, one beat each,
// and emits the CI-increment and staticisor-load strobes.
// Ports: clk, rst (async high), run (free-run level), step (single-step
//        pulse), stop_instr (STP decoded in ACTION); outputs scan1, scan2,
//        ha, halted (state decodes), blackout, digit, ci_inc, stat_load.
module beat_sequencer
    import baby_pkg::*;
#(
    parameter int WORD_DIGITS     = DEF_WORD_DIGITS,
    parameter int BLACKOUT_DIGITS = DEF_BLACKOUT_DIGITS
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic step,
    input  logic stop_instr,
    output logic scan1,
    output logic scan2,
    output logic ha,
    output logic blackout,
    output logic [$clog2(WORD_DIGITS+BLACKOUT_DIGITS)-1:0] digit,
    output logic ci_inc,
    output logic stat_load,
    output logic halted
);

    localparam int BEAT_LEN = WORD_DIGITS + BLACKOUT_DIGITS;
    localparam int DW       = $clog2(BEAT_LEN);

    localparam logic [DW-1:0] WD_V = DW'(WORD_DIGITS);

    beat_state_e state_q, state_d;
    logic        stop_q, stop_d;
    logic        stepm_q, stepm_d;

    logic        scan1_q, scan2_q, ha_q, halted_q;
    logic        blackout_q, ci_inc_q, stat_load_q;

    logic [DW-1:0] cnt;
    logic [DW-1:0] cnt_nxt;
    logic          beat_end;

    // Counter is held at 0 while halted so every instruction
    // starts at SCAN1 digit 0.
    digit_counter #(
        .LEN (BEAT_LEN),
        .W   (DW)
    ) u_digit (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (state_q == ST_HALT),
        .en_i        (1'b1),
        .count_o     (cnt),
        .count_nxt_o (cnt_nxt),
        .tc_o        (beat_end)
    );

    always_comb begin
        state_d = state_q;
        stop_d  = stop_q;
        stepm_d = stepm_q;
        unique case (state_q)
            ST_HALT: begin
                stop_d = 1'b0;
                // run wins over step when both are high
                if (run || step) begin
                    state_d = ST_SCAN1;
                    stepm_d = !run;
                end
            end
            ST_SCAN1: begin
                if (beat_end) state_d = ST_SCAN2;
            end
            ST_SCAN2: begin
                if (beat_end) state_d = ST_ACTION;
            end
            ST_ACTION: begin
                if (stop_instr) stop_d = 1'b1;
                if (beat_end) begin
                    // stop_d folds in a STP seen on the final digit
                    if (stop_d || !run || stepm_q) begin
                        state_d = ST_HALT;
                        stepm_d = 1'b0;
                    end else begin
                        state_d = ST_SCAN1;
                    end
                    stop_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_HALT;
                stop_d  = 1'b0;
                stepm_d = 1'b0;
            end
        endcase
    end

    // Outputs are decoded from next state / next digit so they are
    // registered yet aligned with state_q and digit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_HALT;
            stop_q      <= 1'b0;
            stepm_q     <= 1'b0;
            scan1_q     <= 1'b0;
            scan2_q     <= 1'b0;
            ha_q        <= 1'b0;
            halted_q    <= 1'b1;
            blackout_q  <= 1'b0;
            ci_inc_q    <= 1'b0;
            stat_load_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            stop_q      <= stop_d;
            stepm_q     <= stepm_d;
            scan1_q     <= (state_d == ST_SCAN1);
            scan2_q     <= (state_d == ST_SCAN2);
            ha_q        <= (state_d == ST_ACTION);
            halted_q    <= (state_d == ST_HALT);
            blackout_q  <= (state_d != ST_HALT) && (cnt_nxt >= WD_V);
            ci_inc_q    <= (state_d == ST_SCAN1) && (cnt_nxt == WD_V);
            stat_load_q <= (state_d == ST_SCAN2) && (cnt_nxt == WD_V);
        end
    end

    assign scan1     = scan1_q;
    assign scan2     = scan2_q;
    assign ha        = ha_q;
    assign halted    = halted_q;
    assign blackout  = blackout_q;
    assign ci_inc    = ci_inc_q;
    assign stat_load = stat_load_q;
    assign digit     = cnt;

endmodule
